// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet scheduler.
// Holds the FSM encoding, the default sync byte and the checksum rule.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CHECKSUM,
        ST_GAP
    } state_e;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Byte that brings header+payload+checksum to zero mod 256.
    function automatic logic [7:0] pkt_checksum(input logic [7:0] sum);
        return (~sum) + 8'd1;
    endfunction

endpackage

// File: rtl/uart_pkt_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping around; the pointer register lives in the scheduler.
module rr_arbiter
    import uart_pkt_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant_idx,
    output logic          any_req
);

    logic found;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                grant_idx = PW'((int'(ptr) + k) % N);
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_pkt_scheduler.sv
// Frames packets from several requesters onto a byte-wide valid/ready
// link: header, payload bytes, checksum, then an idle gap.
module uart_pkt_scheduler
    import uart_pkt_pkg::*;
#(
    parameter int         N_REQ       = 2,
    parameter int         PKT_BYTES   = 4,
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER,
    parameter int         GAP_CLKS    = 16,
    localparam int        GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int        PKT_W       = PKT_BYTES * 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*PKT_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [GW-1:0]          grant_id
);

    localparam int IW       = $clog2(PKT_BYTES + 1);
    localparam int CW       = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam int GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

    state_e           state_q;
    logic [PKT_W-1:0] buf_q;
    logic [7:0]       sum_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    gap_q;
    logic [GW-1:0]    ptr_q;
    logic [GW-1:0]    grant_q;

    logic [GW-1:0]    grant_w;
    logic             any_req;
    logic [PKT_W-1:0] slice_w;
    logic [PKT_W-1:0] shift_w;
    logic [7:0]       sum_d;
    logic [GW-1:0]    ptr_d;
    logic             hs;
    logic             last_byte;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (GW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_idx (grant_w),
        .any_req   (any_req)
    );

    always_comb begin
        slice_w = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_w == GW'(i)) begin
                slice_w = req_data[i*PKT_W +: PKT_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state_q == ST_LOAD) && any_req
                           && (grant_w == GW'(i));
        end
    end

    // Payload is consumed by shifting, so the next byte is always at [7:0].
    assign shift_w   = buf_q >> 8;
    assign sum_d     = sum_q + tx_data_q;
    assign ptr_d     = (grant_w == GW'(N_REQ - 1)) ? '0 : grant_w + GW'(1);
    assign hs        = tx_valid_q && tx_ready;
    assign last_byte = (idx_q == IW'(PKT_BYTES - 1));

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            sum_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            idx_q      <= '0;
            gap_q      <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (any_req) begin
                        buf_q      <= slice_w;
                        grant_q    <= grant_w;
                        ptr_q      <= ptr_d;
                        sum_q      <= HEADER_BYTE;
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= HEADER_BYTE;
                        state_q    <= ST_HEADER;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HEADER: begin
                    if (hs) begin
                        tx_data_q <= buf_q[7:0];
                        state_q   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (hs) begin
                        sum_q <= sum_d;
                        idx_q <= idx_q + IW'(1);
                        buf_q <= shift_w;
                        if (last_byte) begin
                            tx_data_q <= pkt_checksum(sum_d);
                            state_q   <= ST_CHECKSUM;
                        end else begin
                            tx_data_q <= shift_w[7:0];
                        end
                    end
                end
                ST_CHECKSUM: begin
                    if (hs) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        gap_q      <= '0;
                        state_q    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == CW'(GAP_LAST)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_scheduler.sv
// Scoreboard bench for uart_pkt_scheduler: a packet-level model predicts
// grants and byte streams, a negedge monitor checks the link.
module tb_uart_pkt_scheduler;

    localparam int N  = 2;
    localparam int PB = 2;
    localparam int G  = 5;
    localparam int PW = PB * 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N*PW-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic [0:0]       grant_id;

    logic             rv [N];
    logic [PW-1:0]    rd [N];

    typedef struct {
        logic [7:0] b;
        int         kind;
        int         gid;
    } exp_t;

    exp_t       expq [$];
    int         glog [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         hs_cnt = 0;
    int         pulse_cnt [N];
    int         mptr = 0;
    int         stall_cnt = 0;
    bit         hs_last = 1'b0;
    bit         prev_pend = 1'b0;
    logic [7:0] prev_data;
    bit         armed = 1'b0;
    int         gcnt = 0;
    logic [7:0] last_chk = 8'h00;

    int         mg;
    int         msum;
    logic [PW-1:0] md;
    logic [7:0] mb;
    exp_t       me;

    uart_pkt_scheduler #(
        .N_REQ       (N),
        .PKT_BYTES   (PB),
        .HEADER_BYTE (8'hA5),
        .GAP_CLKS    (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = rv[i];
            req_data[i*PW +: PW]  = rd[i];
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return 0;
    endfunction

    // uart_tx stand-in: drops ready after each accept, else random.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                stall_cnt--;
                tx_ready = 1'b0;
            end else if (hs_last) begin
                tx_ready = 1'b0;
            end else begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_pend = 1'b0;
            armed     = 1'b0;
            hs_last   = 1'b0;
        end else begin
            if (req_ready != '0) begin
                mg = pick();
                check("req_ready_grant", 32'(req_ready), 32'(1) << mg);
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        pulse_cnt[i]++;
                        glog.push_back(i);
                    end
                end
                md   = req_data[mg*PW +: PW];
                msum = 'hA5;
                expq.push_back('{8'hA5, 0, mg});
                for (int b = 0; b < PB; b++) begin
                    mb = md[b*8 +: 8];
                    msum += int'(mb);
                    expq.push_back('{mb, 1, mg});
                end
                expq.push_back('{8'((256 - (msum % 256)) % 256), 2, mg});
                mptr = (mg + 1) % N;
            end
            if (armed) begin
                gcnt++;
                if (!busy) begin
                    check("gap_len", 32'(gcnt), 32'(G + 1));
                    armed = 1'b0;
                end else begin
                    check("gap_txvalid", 32'(tx_valid), 32'(0));
                    if (gcnt > G + 4) begin
                        check("gap_len", 32'(gcnt), 32'(G + 1));
                        armed = 1'b0;
                    end
                end
            end
            if (prev_pend) begin
                check("hold_valid", 32'(tx_valid), 32'(1));
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                hs_last   = 1'b1;
                prev_pend = 1'b0;
                if (expq.size() == 0) begin
                    check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    me = expq.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(me.b));
                    if (me.kind == 0) check("grant_id", 32'(grant_id), 32'(me.gid));
                    if (me.kind == 2) begin
                        last_chk = tx_data;
                        armed    = 1'b1;
                        gcnt     = 0;
                    end
                end
            end else begin
                hs_last   = 1'b0;
                prev_pend = tx_valid;
                prev_data = tx_data;
            end
        end
    end

    task automatic send(input int id, input int npk, input bit rnd,
                        input bit hold_in, input logic [PW-1:0] d0);
        int t;
        bit hold;
        for (int k = 0; k < npk; k++) begin
            @(posedge clk);
            #1;
            rv[id] = 1'b1;
            rd[id] = rnd ? PW'($urandom) : d0;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!req_ready[id] && t < 3000);
            check("req_ready_wait", 32'(req_ready[id]), 32'(1));
            hold = rnd ? bit'($urandom_range(0, 1)) : hold_in;
            if (!(hold && k < npk - 1)) begin
                @(posedge clk);
                #1;
                rv[id] = 1'b0;
                if (rnd) repeat ($urandom_range(0, 8)) @(posedge clk);
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((expq.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue", 32'(expq.size()), 32'(0));
        check("drain_idle", 32'(busy), 32'(0));
    endtask

    task automatic wait_hs(input int target);
        int t;
        t = 0;
        while (hs_cnt < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("wait_hs", 32'(hs_cnt >= target), 32'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_txvalid", 32'(tx_valid), 32'(0));
        check("rst_txdata", 32'(tx_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_grant", 32'(grant_id), 32'(0));
        check("rst_reqready", 32'(req_ready), 32'(0));
        expq.delete();
        mptr      = 0;
        stall_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int b0;
        int b1;
        int base;
        int vcnt;
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int b1;
        int base;
        int vcnt;
        for (int i = 0; i < N; i++) begin
            rv[i]        = 1'b0;
            rd[i]        = '0;
            pulse_cnt[i] = 0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_txvalid", 32'(tx_valid), 32'(0));
        check("init_txdata", 32'(tx_data), 32'(0));
        check("init_busy", 32'(busy), 32'(0));
        check("init_grant", 32'(grant_id), 32'(0));
        check("init_reqready", 32'(req_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        b0 = pulse_cnt[0];
        send(0, 1, 1'b0, 1'b0, 16'h2010);
        wait_idle();
        check("single_pulses", 32'(pulse_cnt[0] - b0), 32'(1));
        check("single_chk", 32'(last_chk), 32'h2B);

        send(0, 1, 1'b0, 1'b0, 16'hFFFF);
        wait_idle();
        check("wrap_chk", 32'(last_chk), 32'h5D);

        do_reset();
        glog.delete();
        b0 = pulse_cnt[0];
        b1 = pulse_cnt[1];
        fork
            send(0, 2, 1'b0, 1'b1, 16'h1111);
            send(1, 2, 1'b0, 1'b1, 16'h2222);
        join
        wait_idle();
        check("rr_count", 32'(glog.size()), 32'(4));
        if (glog.size() == 4) begin
            check("rr_g0", 32'(glog[0]), 32'(0));
            check("rr_g1", 32'(glog[1]), 32'(1));
            check("rr_g2", 32'(glog[2]), 32'(0));
            check("rr_g3", 32'(glog[3]), 32'(1));
        end
        check("rr_pulses0", 32'(pulse_cnt[0] - b0), 32'(2));
        check("rr_pulses1", 32'(pulse_cnt[1] - b1), 32'(2));

        base = hs_cnt;
        fork
            send(1, 1, 1'b0, 1'b0, 16'h7788);
            begin
                wait_hs(base + 1);
                stall_cnt = 50;
            end
        join
        wait_idle();
        check("bp_handshakes", 32'(hs_cnt - base), 32'(PB + 2));

        base = hs_cnt;
        fork
            send(0, 1, 1'b0, 1'b0, 16'h3344);
            begin
                wait_hs(base + 2);
                stall_cnt = 50;
            end
        join
        repeat (5) @(posedge clk);
        do_reset();
        send(1, 1, 1'b0, 1'b0, 16'h5566);
        wait_idle();
        check("post_rst_grant", 32'(glog[glog.size() - 1]), 32'(1));

        b0   = pulse_cnt[0];
        base = hs_cnt;
        @(posedge clk);
        #1;
        rv[0] = 1'b1;
        rd[0] = 16'hDEAD;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        vcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid) vcnt++;
        end
        check("wd_txvalid", 32'(vcnt), 32'(0));
        check("wd_pulses", 32'(pulse_cnt[0] - b0), 32'(0));
        check("wd_hs", 32'(hs_cnt - base), 32'(0));
        check("wd_busy", 32'(busy), 32'(0));

        fork
            send(0, 8, 1'b1, 1'b0, '0);
            send(1, 8, 1'b1, 1'b0, '0);
        join
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
